add_seq: RTL

Multi-cycle adder controller that sequences a single 4-bit ripple-carry adder slice to add two WIDTH-bit operands nibble by nibble, LSB nibble first, with the carry registered between cycles. It sits between a requester holding full-width operands and the shared narrow adder. It trades latency for area and exposes a valid/ready handshake on both sides.

---
 rtl/add_seq_pkg.sv | 24 ++
 rtl/add_seq_rip_carry.sv | 23 ++
 rtl/add_seq.sv | 123 ++++++++++++
 3 files changed

// File: rtl/add_seq_pkg.sv
// Shared types and constants for the nibble-serial adder controller add_seq.
package add_seq_pkg;

  localparam int unsigned NIBBLE = 4;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  // Width of a counter able to index every nibble of a width-bit operand.
  function automatic int unsigned cnt_width(input int unsigned width);
    int unsigned n;
    int unsigned w;
    n = width / NIBBLE;
    w = 1;
    for (int unsigned i = 1; i < 32; i++) begin
      if ((32'd1 << i) < n) w = i + 1;
    end
    return w;
  endfunction

endpackage

// File: rtl/add_seq_rip_carry.sv
// Existing 4-bit ripple-carry adder slice (rip_carry), shared by add_seq.
module rip_carry (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] sum,
  output logic       carry
);

  logic [4:0] c;

  always_comb begin
    c    = '0;
    sum  = '0;
    c[0] = cin;
    for (int unsigned i = 0; i < 4; i++) begin
      sum[i]   = a[i] ^ b[i] ^ c[i];
      c[i+1]   = (a[i] & b[i]) | (a[i] & c[i]) | (b[i] & c[i]);
    end
    carry = c[4];
  end

endmodule

// File: rtl/add_seq.sv
// Multi-cycle adder: sequences one rip_carry slice over WIDTH/4 nibbles, LSB first.
// Optional subtract mode via `define ADD_SEQ_SUB_EN.
module add_seq
  import add_seq_pkg::*;
#(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             op_sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int unsigned N    = WIDTH / NIBBLE;
  localparam int unsigned CW   = cnt_width(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  state_t           state;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] sum_q;
  logic             carry_q;
  logic [CW-1:0]    nib_cnt;
  logic             in_ready_q;
  logic             out_valid_q;

  logic [NIBBLE-1:0] a_nib;
  logic [NIBBLE-1:0] b_nib;
  logic [NIBBLE-1:0] s_nib;
  logic              s_carry;

`ifdef ADD_SEQ_SUB_EN
  logic sub_q;
`else
  logic unused_op_sub;
  assign unused_op_sub = op_sub;
`endif

  always_comb begin
    a_nib = a_q[nib_cnt*NIBBLE +: NIBBLE];
    b_nib = b_q[nib_cnt*NIBBLE +: NIBBLE];
`ifdef ADD_SEQ_SUB_EN
    b_nib = b_nib ^ {NIBBLE{sub_q}};
`endif
  end

  rip_carry u_slice (
    .a     (a_nib),
    .b     (b_nib),
    .cin   (carry_q),
    .sum   (s_nib),
    .carry (s_carry)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      a_q         <= '0;
      b_q         <= '0;
      sum_q       <= '0;
      carry_q     <= 1'b0;
      nib_cnt     <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
`ifdef ADD_SEQ_SUB_EN
      sub_q       <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_q        <= a;
            b_q        <= b;
            nib_cnt    <= '0;
            in_ready_q <= 1'b0;
            state      <= RUN;
`ifdef ADD_SEQ_SUB_EN
            sub_q      <= op_sub;
            carry_q    <= op_sub ? 1'b1 : cin;
`else
            carry_q    <= cin;
`endif
          end
        end
        RUN: begin
          sum_q[nib_cnt*NIBBLE +: NIBBLE] <= s_nib;
          carry_q <= s_carry;
          nib_cnt <= nib_cnt + 1'b1;
          if (nib_cnt == LAST) begin
            state       <= DONE;
            out_valid_q <= 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            state       <= IDLE;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
          end
        end
        default: begin
          state       <= IDLE;
          out_valid_q <= 1'b0;
          in_ready_q  <= 1'b1;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign sum       = sum_q;
  assign cout      = carry_q;

endmodule
